// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - htrans encodings shared by the arbiter and the AHB-to-APB bridge
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    // SEQ and BUSY both mean the master is inside a burst it has not finished
    function automatic logic is_mid_burst(input logic [1:0] trans);
        return (trans == SEQ) || (trans == BUSY);
    endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// rtl/ahb_bridge_arbiter_if.sv - two-master request/transfer bundle plus the muxed bridge-side signals
interface ahb_bridge_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        hbusreq;
    logic [1:0]        hlock;
    logic [1:0]        htrans_m0;
    logic [1:0]        htrans_m1;
    logic [ADDR_W-1:0] haddr_m0;
    logic [ADDR_W-1:0] haddr_m1;
    logic              hwrite_m0;
    logic              hwrite_m1;
    logic [DATA_W-1:0] hwdata_m0;
    logic [DATA_W-1:0] hwdata_m1;
    logic [1:0]        hgrant;
    logic              hmaster;
    logic              hmastlock;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [DATA_W-1:0] hwdata;
    logic              hreadyin;
    logic              bridge_hreadyout;

    modport slave (
        input  hbusreq, hlock, htrans_m0, htrans_m1, haddr_m0, haddr_m1,
        input  hwrite_m0, hwrite_m1, hwdata_m0, hwdata_m1, bridge_hreadyout,
        output hgrant, hmaster, hmastlock, htrans, haddr, hwrite, hwdata, hreadyin
    );

    modport master (
        output hbusreq, hlock, htrans_m0, htrans_m1, haddr_m0, haddr_m1,
        output hwrite_m0, hwrite_m1, hwdata_m0, hwdata_m1, bridge_hreadyout,
        input  hgrant, hmaster, hmastlock, htrans, haddr, hwrite, hwdata, hreadyin
    );
endinterface

// File: rtl/ahb_rr_grant.sv
// rtl/ahb_rr_grant.sv - decides whether this cycle is an arbitration point and which master owns the bus next
module ahb_rr_grant
    import ahb_apb_pkg::*;
(
    input  logic [1:0] hbusreq,
    input  logic [1:0] hlock,
    input  logic       owner,
    input  logic [1:0] htrans_owner,
    input  logic       hready,
    input  logic       force_arb,
    output logic       arb_point,
    output logic       next_owner
);
    logic other;
    logic locked;
    logic mid_burst;

    assign other = ~owner;

    always_comb begin
        locked     = hlock[owner] & hbusreq[owner];
        mid_burst  = is_mid_burst(htrans_owner);
        // an overdue hold may break a lock, but never a burst in progress
        arb_point  = hready & ~mid_burst & (~locked | force_arb);
        next_owner = owner;
        if (arb_point && hbusreq[other]) begin
            next_owner = other;
        end
    end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// rtl/ahb_bridge_arbiter.sv - two-master round-robin arbiter and pipelined mux in front of the AHB-to-APB bridge
// Optional lock timeout: ARB_TIMEOUT_EN
module ahb_bridge_arbiter
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    ahb_bridge_arbiter_if.slave  bus
);
    logic              hready;
    logic              hmaster_q, hmaster_d;
    logic              dmaster_q, dmaster_d;
    logic              hmastlock_q, hmastlock_d;
    logic [1:0]        htrans_own;
    logic [ADDR_W-1:0] haddr_own;
    logic              hwrite_own;
    logic [DATA_W-1:0] hwdata_own;
    logic              arb_point;
    logic              next_owner;
    logic              force_arb;

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be at least 1");
    end

    assign hready = bus.bridge_hreadyout;

    always_comb begin
        htrans_own = bus.htrans_m0;
        haddr_own  = bus.haddr_m0;
        hwrite_own = bus.hwrite_m0;
        if (hmaster_q) begin
            htrans_own = bus.htrans_m1;
            haddr_own  = bus.haddr_m1;
            hwrite_own = bus.hwrite_m1;
        end
        // write data belongs to whoever owned the previous accepted address phase
        hwdata_own = dmaster_q ? bus.hwdata_m1 : bus.hwdata_m0;
    end

    ahb_rr_grant u_rr_grant (
        .hbusreq      (bus.hbusreq),
        .hlock        (bus.hlock),
        .owner        (hmaster_q),
        .htrans_owner (htrans_own),
        .hready       (hready),
        .force_arb    (force_arb),
        .arb_point    (arb_point),
        .next_owner   (next_owner)
    );

    always_comb begin
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        dmaster_d   = dmaster_q;
        if (arb_point) begin
            hmaster_d   = next_owner;
            hmastlock_d = bus.hlock[next_owner];
        end
        if (hready) begin
            dmaster_d = hmaster_q;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // counts cycles the waiting master has been kept off the bus; saturates at HOLD_MAX
    always_comb begin
        hold_d = hold_q;
        if (hmaster_d != hmaster_q) begin
            hold_d = '0;
        end else if (bus.hbusreq[~hmaster_q] && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    assign force_arb = (hold_q == HOLD_MAX);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign force_arb = 1'b0;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hmaster_q   <= 1'b0;
            dmaster_q   <= 1'b0;
            hmastlock_q <= 1'b0;
        end else begin
            hmaster_q   <= hmaster_d;
            dmaster_q   <= dmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign bus.hgrant    = hmaster_q ? 2'b10 : 2'b01;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;
    assign bus.htrans    = hresetn ? htrans_own : IDLE;
    assign bus.haddr     = haddr_own;
    assign bus.hwrite    = hwrite_own;
    assign bus.hwdata    = hwdata_own;
    assign bus.hreadyin  = hready;

endmodule
